// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command and error encodings, init FSM states,
// the command-strobe decoder and the mode-word legality check.
package sdram_pkg;

    localparam int unsigned CMD_W      = 3;
    localparam int unsigned ERR_W      = 3;
    localparam int unsigned AREF_CNT_W = 4;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP  = 3'd0,
        CMD_ACT  = 3'd1,
        CMD_RD   = 3'd2,
        CMD_WR   = 3'd3,
        CMD_BST  = 3'd4,
        CMD_PRE  = 3'd5,
        CMD_AREF = 3'd6,
        CMD_LMR  = 3'd7
    } cmd_t;

    typedef enum logic [ERR_W-1:0] {
        ERR_NONE  = 3'd0,
        ERR_PWR   = 3'd1,
        ERR_ORDER = 3'd2,
        ERR_TRP   = 3'd3,
        ERR_TRFC  = 3'd4,
        ERR_TMRD  = 3'd5,
        ERR_MODE  = 3'd6,
        ERR_CKE   = 3'd7
    } err_t;

    typedef enum logic [1:0] {
        ST_PWR_WAIT  = 2'd0,
        ST_WAIT_AREF = 2'd1,
        ST_READY     = 2'd2,
        ST_ERR       = 2'd3
    } init_state_t;

    // Deselect (cs_n high) is treated as NOP.
    function automatic cmd_t cmd_decode(input logic cs_n, input logic ras_n,
                                        input logic cas_n, input logic we_n);
        cmd_t c;
        c = CMD_NOP;
        if (!cs_n) begin
            case ({ras_n, cas_n, we_n})
                3'b111:  c = CMD_NOP;
                3'b011:  c = CMD_ACT;
                3'b101:  c = CMD_RD;
                3'b100:  c = CMD_WR;
                3'b110:  c = CMD_BST;
                3'b010:  c = CMD_PRE;
                3'b001:  c = CMD_AREF;
                3'b000:  c = CMD_LMR;
                default: c = CMD_NOP;
            endcase
        end
        return c;
    endfunction

    // Mode word is illegal for CAS latency outside {2,3}, addr[3] set, or a reserved burst length.
    function automatic logic mode_illegal(input logic [2:0] cl, input logic bt,
                                          input logic [2:0] bl);
        logic cl_bad;
        logic bl_bad;
        cl_bad = !((cl == 3'd2) || (cl == 3'd3));
        bl_bad = (bl == 3'b100) || (bl == 3'b101) || (bl == 3'b110);
        return cl_bad || bt || bl_bad;
    endfunction

endpackage

// File: rtl/sdram_gap_timer.sv
// Command spacing timer: loads a cycle count, counts down to zero, busy while non-zero.
//  clk, rst_n   clock / async active-low reset
//  load         load load_val this cycle (takes precedence over counting)
//  load_val     cycles to hold busy after the loading edge
//  count        current remaining count (registered)
//  busy_c       count != 0
module sdram_gap_timer #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         busy_c
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign busy_c = (count != '0);

endmodule

// File: rtl/sdram_init_monitor.sv
// SDRAM power-up sequence monitor: decodes the sampled command bus, checks
// init order and command spacing, latches the mode register and flags the first violation.
//  sclk, srst_n               clock / async active-low reset
//  cke, cs_n, ras_n, cas_n, we_n, ba, addr   sampled SDRAM command bus
//  cmd                        decoded command of the last sampled cycle
//  init_done                  init sequence complete
//  mode_reg, cas_lat, burst_len   latched mode word and its fields
//  aref_cnt                   auto-refreshes seen during init (saturating)
//  err, err_code              sticky error flag and first error cause
module sdram_init_monitor
    import sdram_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned BA_W    = 2,
    parameter int unsigned PWR_CYC = 10000,
    parameter int unsigned T_RP    = 2,
    parameter int unsigned T_RFC   = 7,
    parameter int unsigned T_MRD   = 2,
    parameter int unsigned AREF_N  = 2
) (
    input  logic                  sclk,
    input  logic                  srst_n,
    input  logic                  cke,
    input  logic                  cs_n,
    input  logic                  ras_n,
    input  logic                  cas_n,
    input  logic                  we_n,
    input  logic [BA_W-1:0]       ba,
    input  logic [ADDR_W-1:0]     addr,
    output cmd_t                  cmd,
    output logic                  init_done,
    output logic [ADDR_W-1:0]     mode_reg,
    output logic [2:0]            cas_lat,
    output logic [2:0]            burst_len,
    output logic [AREF_CNT_W-1:0] aref_cnt,
    output logic                  err,
    output logic [ERR_W-1:0]      err_code
);

    localparam int unsigned PWR_W  = $clog2(PWR_CYC + 1);
    localparam int unsigned T_MAX  = (T_RP > T_RFC) ? ((T_RP > T_MRD) ? T_RP : T_MRD)
                                                    : ((T_RFC > T_MRD) ? T_RFC : T_MRD);
    localparam int unsigned GAP_W  = $clog2(T_MAX + 1);

    init_state_t           state_q, state_d;
    logic [PWR_W-1:0]      pwr_cnt_q;
    logic                  init_done_d;
    logic [ADDR_W-1:0]     mode_d;
    logic [AREF_CNT_W-1:0] aref_d;
    logic                  err_d;
    err_t                  code_q, code_d;
    err_t                  gap_src_q, gap_src_d;

    logic                  tmr_load;
    logic [GAP_W-1:0]      tmr_val;
    logic [GAP_W-1:0]      tmr_cnt;
    logic                  tmr_busy_c;

    cmd_t                  cmd_c;
    logic                  is_nop_c;
    logic                  pre_all_c;
    logic                  pwr_ok_c;
    logic                  mode_bad_c;
    logic                  order_bad_c;
    err_t                  cause_c;

    // Bank address carries no meaning for init checking.
    logic                  ba_unused;
    assign ba_unused = ^ba;

    sdram_gap_timer #(
        .W (GAP_W)
    ) u_gap_timer (
        .clk      (sclk),
        .rst_n    (srst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_cnt),
        .busy_c   (tmr_busy_c)
    );

    assign cmd_c      = cmd_decode(cs_n, ras_n, cas_n, we_n);
    assign is_nop_c   = (cmd_c == CMD_NOP);
    assign pre_all_c  = (cmd_c == CMD_PRE) && addr[10];
    assign pwr_ok_c   = (pwr_cnt_q >= PWR_W'(PWR_CYC));
    assign mode_bad_c = (cmd_c == CMD_LMR) && mode_illegal(addr[6:4], addr[3], addr[2:0]);

    // Commands that are out of sequence for the current init phase.
    always_comb begin
        order_bad_c = 1'b0;
        case (state_q)
            ST_PWR_WAIT:  order_bad_c = !is_nop_c && !pre_all_c;
            ST_WAIT_AREF: order_bad_c = !(is_nop_c || pre_all_c || (cmd_c == CMD_AREF) ||
                                          ((cmd_c == CMD_LMR) &&
                                           (aref_cnt >= AREF_CNT_W'(AREF_N))));
            default:      order_bad_c = 1'b0;
        endcase
    end

    // Error cause with fixed priority 1,3/4/5,2,6,7.
    always_comb begin
        cause_c = ERR_NONE;
        if ((state_q == ST_PWR_WAIT) && !is_nop_c && !pwr_ok_c) begin
            cause_c = ERR_PWR;
        end else if (tmr_busy_c && !is_nop_c) begin
            cause_c = gap_src_q;
        end else if (order_bad_c) begin
            cause_c = ERR_ORDER;
        end else if (mode_bad_c) begin
            cause_c = ERR_MODE;
        end else if (!cke && ((state_q == ST_PWR_WAIT) || (state_q == ST_WAIT_AREF))) begin
            cause_c = ERR_CKE;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        init_done_d = init_done;
        mode_d      = mode_reg;
        aref_d      = aref_cnt;
        err_d       = err;
        code_d      = code_q;
        gap_src_d   = gap_src_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        if (state_q != ST_ERR) begin
            if (cause_c != ERR_NONE) begin
                state_d     = ST_ERR;
                err_d       = 1'b1;
                code_d      = cause_c;
                init_done_d = 1'b0;
            end else begin
                case (cmd_c)
                    CMD_PRE: begin
                        tmr_load  = 1'b1;
                        tmr_val   = GAP_W'(T_RP);
                        gap_src_d = ERR_TRP;
                    end
                    CMD_AREF: begin
                        tmr_load  = 1'b1;
                        tmr_val   = GAP_W'(T_RFC);
                        gap_src_d = ERR_TRFC;
                    end
                    CMD_LMR: begin
                        tmr_load  = 1'b1;
                        tmr_val   = GAP_W'(T_MRD);
                        gap_src_d = ERR_TMRD;
                    end
                    default: ;
                endcase

                case (state_q)
                    ST_PWR_WAIT: begin
                        if (pre_all_c) state_d = ST_WAIT_AREF;
                    end
                    ST_WAIT_AREF: begin
                        if ((cmd_c == CMD_AREF) && (aref_cnt != '1)) begin
                            aref_d = aref_cnt + AREF_CNT_W'(1);
                        end
                        if (cmd_c == CMD_LMR) begin
                            mode_d  = addr;
                            state_d = ST_READY;
                        end
                    end
                    ST_READY: begin
                        if (cmd_c == CMD_LMR) mode_d = addr;
                        // Done once the tMRD window of the init LMR has run out.
                        if (!tmr_load && (tmr_cnt <= GAP_W'(1))) init_done_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            state_q   <= ST_PWR_WAIT;
            pwr_cnt_q <= '0;
            cmd       <= CMD_NOP;
            init_done <= 1'b0;
            mode_reg  <= '0;
            aref_cnt  <= '0;
            err       <= 1'b0;
            code_q    <= ERR_NONE;
            gap_src_q <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            if (!pwr_ok_c) pwr_cnt_q <= pwr_cnt_q + PWR_W'(1);
            cmd       <= cmd_c;
            init_done <= init_done_d;
            mode_reg  <= mode_d;
            aref_cnt  <= aref_d;
            err       <= err_d;
            code_q    <= code_d;
            gap_src_q <= gap_src_d;
        end
    end

    assign err_code  = code_q;
    assign cas_lat   = mode_reg[6:4];
    assign burst_len = mode_reg[2:0];

endmodule
